// File: rtl/wb_master_seq_if.sv
`default_nettype none
// ============================================================================
// Module : wb_master_seq_if
// Brief  : Command/response handshake and classic Wishbone B4 master signals.
// Rev    : 1.0  initial release
// ============================================================================
interface wb_master_seq_if #(
    parameter int ADR_W = 30
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_we;
    logic [ADR_W-1:0] cmd_adr;
    logic [31:0]      cmd_dat;
    logic [3:0]       cmd_sel;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_dat;
    logic             rsp_err;
    logic             rsp_timeout;

    logic [ADR_W-1:0] wishbone_adr;
    logic [31:0]      wishbone_datwr;
    logic [31:0]      wishbone_datrd;
    logic [3:0]       wishbone_sel;
    logic             wishbone_cyc;
    logic             wishbone_stb;
    logic             wishbone_we;
    logic [2:0]       wishbone_cti;
    logic [1:0]       wishbone_bte;
    logic             wishbone_ack;
    logic             wishbone_err;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
               wishbone_datrd, wishbone_ack, wishbone_err,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err, rsp_timeout,
               wishbone_adr, wishbone_datwr, wishbone_sel, wishbone_cyc,
               wishbone_stb, wishbone_we, wishbone_cti, wishbone_bte
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
               wishbone_datrd, wishbone_ack, wishbone_err,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err, rsp_timeout,
               wishbone_adr, wishbone_datwr, wishbone_sel, wishbone_cyc,
               wishbone_stb, wishbone_we, wishbone_cti, wishbone_bte
    );
endinterface
`default_nettype wire

// File: rtl/wb_master_seq.sv
`default_nettype none
// ============================================================================
// Module : wb_master_seq
// Brief  : Single-command Wishbone B4 classic master with wait-state timeout.
// Rev    : 1.0  initial release
// ============================================================================
module wb_master_seq #(
    parameter int TIMEOUT = 255,
    parameter int ADR_W   = 30
) (
    input  logic            clk48_host,
    input  logic            reset,
    wb_master_seq_if.master bus
);
    localparam logic [1:0]  c_st_idle = 2'd0;
    localparam logic [1:0]  c_st_bus  = 2'd1;
    localparam logic [1:0]  c_st_resp = 2'd2;
    localparam logic [15:0] c_timeout = 16'(TIMEOUT);

    logic [1:0]       r_state;
    logic             r_cmd_ready;
    logic             r_cyc;
    logic             r_we;
    logic [ADR_W-1:0] r_adr;
    logic [31:0]      r_datwr;
    logic [3:0]       r_sel;
    logic [15:0]      r_wait;
    logic             r_rsp_valid;
    logic [31:0]      r_rsp_dat;
    logic             r_rsp_err;
    logic             r_rsp_timeout;

    always_ff @(posedge clk48_host or negedge reset) begin
        if (!reset) begin
            r_state       <= c_st_idle;
            r_cmd_ready   <= 1'b0;
            r_cyc         <= 1'b0;
            r_we          <= 1'b0;
            r_adr         <= '0;
            r_datwr       <= '0;
            r_sel         <= '0;
            r_wait        <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_dat     <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    // cmd_ready is registered so it stays low through reset
                    if (bus.cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_we        <= bus.cmd_we;
                        r_adr       <= bus.cmd_adr;
                        r_datwr     <= bus.cmd_dat;
                        r_sel       <= bus.cmd_sel;
                        r_cyc       <= 1'b1;
                        r_wait      <= '0;
                        r_state     <= c_st_bus;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                c_st_bus: begin
                    if (bus.wishbone_ack || bus.wishbone_err) begin
                        // err wins over a simultaneous ack and suppresses data
                        r_cyc         <= 1'b0;
                        r_rsp_dat     <= (bus.wishbone_err || r_we) ? 32'h0 : bus.wishbone_datrd;
                        r_rsp_err     <= bus.wishbone_err;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= c_st_resp;
                    end else if (r_wait == c_timeout) begin
                        r_cyc         <= 1'b0;
                        r_rsp_dat     <= 32'h0;
                        r_rsp_err     <= 1'b0;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= c_st_resp;
                    end else begin
                        r_wait <= r_wait + 16'd1;
                    end
                end
                c_st_resp: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= c_st_idle;
                    end
                end
                default: begin
                    r_cyc       <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b0;
                    r_state     <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.cmd_ready      = r_cmd_ready;
    assign bus.rsp_valid      = r_rsp_valid;
    assign bus.rsp_dat        = r_rsp_dat;
    assign bus.rsp_err        = r_rsp_err;
    assign bus.rsp_timeout    = r_rsp_timeout;
    assign bus.wishbone_adr   = r_adr;
    assign bus.wishbone_datwr = r_datwr;
    assign bus.wishbone_sel   = r_sel;
    assign bus.wishbone_we    = r_we;
    assign bus.wishbone_cyc   = r_cyc;
    assign bus.wishbone_stb   = r_cyc;
    assign bus.wishbone_cti   = 3'b000;
    assign bus.wishbone_bte   = 2'b00;
endmodule
`default_nettype wire

// File: tb/tb_wb_master_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_master_seq
// Brief  : Directed scoreboard bench for wb_master_seq with a Wishbone slave model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_wb_master_seq;
    logic clk48_host = 1'b0;
    logic reset      = 1'b0;
    always #5 clk48_host = ~clk48_host;

    wb_master_seq_if #(.ADR_W(30)) bus ();

    wb_master_seq #(.TIMEOUT(8), .ADR_W(30)) dut (
        .clk48_host (clk48_host),
        .reset      (reset),
        .bus        (bus)
    );

    typedef struct {
        logic [31:0] dat;
        logic        err;
        logic        tmo;
        int          cyc_len;
    } rsp_t;

    rsp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    // slave model knobs
    int          slave_wait   = 0;
    bit          slave_ack    = 1'b1;
    bit          slave_err    = 1'b0;
    bit          slave_silent = 1'b0;
    logic [31:0] slave_dat    = 32'h0;
    bit          inject_ack   = 1'b0;

    // bus monitor state
    int          cyc_run      = 0;
    int          last_cyc_len = 0;
    bit          unstable     = 1'b0;
    logic [29:0] cap_adr;
    logic [31:0] cap_dat;
    logic [3:0]  cap_sel;
    logic        cap_we;
    bit          respond;

    always @(negedge clk48_host) begin
        if (bus.wishbone_cyc) begin
            if (cyc_run == 0) begin
                cap_adr = bus.wishbone_adr;
                cap_dat = bus.wishbone_datwr;
                cap_sel = bus.wishbone_sel;
                cap_we  = bus.wishbone_we;
            end else if (cap_adr !== bus.wishbone_adr || cap_dat !== bus.wishbone_datwr ||
                         cap_sel !== bus.wishbone_sel || cap_we !== bus.wishbone_we) begin
                unstable = 1'b1;
            end
            if (bus.wishbone_stb !== 1'b1) unstable = 1'b1;
            cyc_run++;
            respond = !slave_silent && (cyc_run > slave_wait);
        end else begin
            if (cyc_run != 0) last_cyc_len = cyc_run;
            cyc_run = 0;
            respond = 1'b0;
        end
        bus.wishbone_ack   = (respond && slave_ack) || inject_ack;
        bus.wishbone_err   = respond && slave_err;
        bus.wishbone_datrd = respond ? slave_dat : 32'h0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive_cmd(input logic we, input logic [29:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input bit push, input logic [31:0] e_dat,
                             input logic e_err, input logic e_tmo, input int e_len);
        rsp_t e;
        bus.cmd_we    = we;
        bus.cmd_adr   = adr;
        bus.cmd_dat   = dat;
        bus.cmd_sel   = sel;
        bus.cmd_valid = 1'b1;
        unstable      = 1'b0;
        if (push) begin
            e.dat = e_dat; e.err = e_err; e.tmo = e_tmo; e.cyc_len = e_len;
            sb.push_back(e);
        end
    endtask

    task automatic accept_cmd();
        bit accepted = 1'b0;
        int n = 0;
        while (!accepted && n < 50) begin
            @(negedge clk48_host);
            accepted = bus.cmd_ready;
            @(posedge clk48_host);
            #1;
            n++;
        end
        bus.cmd_valid = 1'b0;
        check("cmd_accepted", accepted, 1);
        check("ready_low_after_accept", bus.cmd_ready, 0);
        check("cyc_next_cycle", bus.wishbone_cyc, 1);
    endtask

    task automatic wait_rsp(input int ready_delay, input bit late_ack);
        bit   seen = 1'b0;
        int   n = 0;
        rsp_t e;
        while (!seen && n < 100) begin
            @(negedge clk48_host);
            #1;
            seen = bus.rsp_valid;
            n++;
        end
        check("rsp_seen", seen, 1);
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("rsp_dat", bus.rsp_dat, e.dat);
        check("rsp_err", bus.rsp_err, e.err);
        check("rsp_timeout", bus.rsp_timeout, e.tmo);
        check("cyc_len", last_cyc_len, e.cyc_len);
        check("cyc_low_in_resp", bus.wishbone_cyc, 0);
        check("ready_low_in_resp", bus.cmd_ready, 0);
        inject_ack = late_ack;
        for (int i = 0; i < ready_delay; i++) begin
            @(negedge clk48_host);
            #1;
            check("hold_valid", bus.rsp_valid, 1);
            check("hold_dat", bus.rsp_dat, e.dat);
            check("hold_err", bus.rsp_err, e.err);
            check("hold_timeout", bus.rsp_timeout, e.tmo);
            check("hold_ready_low", bus.cmd_ready, 0);
            check("hold_cyc_low", bus.wishbone_cyc, 0);
        end
        inject_ack    = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk48_host);
        #1;
        bus.rsp_ready = 1'b0;
        check("valid_drop", bus.rsp_valid, 0);
        check("ready_after_rsp", bus.cmd_ready, 1);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = '0;
        bus.cmd_dat   = '0;
        bus.cmd_sel   = '0;
        bus.rsp_ready = 1'b0;

        // reset values
        repeat (3) @(negedge clk48_host);
        #1;
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_rsp_timeout", bus.rsp_timeout, 0);
        check("rst_rsp_dat", bus.rsp_dat, 0);
        check("rst_cyc", bus.wishbone_cyc, 0);
        check("rst_stb", bus.wishbone_stb, 0);
        check("rst_we", bus.wishbone_we, 0);
        check("rst_adr", bus.wishbone_adr, 0);
        check("rst_datwr", bus.wishbone_datwr, 0);
        check("rst_sel", bus.wishbone_sel, 0);
        reset = 1'b1;
        @(posedge clk48_host);
        #1;
        check("ready_after_release", bus.cmd_ready, 1);

        // write, two wait states
        slave_wait = 2; slave_ack = 1'b1; slave_err = 1'b0; slave_dat = 32'h5A5A5A5A;
        drive_cmd(1'b1, 30'h100, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0, 3);
        accept_cmd();
        check("wr_cti", bus.wishbone_cti, 0);
        check("wr_bte", bus.wishbone_bte, 0);
        wait_rsp(0, 1'b0);
        check("wr_we", cap_we, 1);
        check("wr_adr", cap_adr, 30'h100);
        check("wr_datwr", cap_dat, 32'hDEADBEEF);
        check("wr_sel", cap_sel, 4'hF);
        check("wr_stable", unstable, 0);

        // read, immediate ack
        slave_wait = 0; slave_dat = 32'h12345678;
        drive_cmd(1'b0, 30'h004, 32'h0, 4'hF, 1'b1, 32'h12345678, 1'b0, 1'b0, 1);
        accept_cmd();
        wait_rsp(0, 1'b0);
        check("rd_we", cap_we, 0);
        check("rd_adr", cap_adr, 30'h004);

        // timeout with a late ack while the response waits
        slave_silent = 1'b1;
        drive_cmd(1'b0, 30'h020, 32'h0, 4'hF, 1'b1, 32'h0, 1'b0, 1'b1, 9);
        accept_cmd();
        wait_rsp(3, 1'b1);
        check("to_stable", unstable, 0);
        slave_silent = 1'b0;

        // ack and err together
        slave_wait = 1; slave_ack = 1'b1; slave_err = 1'b1; slave_dat = 32'hFFFF0000;
        drive_cmd(1'b0, 30'h008, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1, 1'b0, 2);
        accept_cmd();
        wait_rsp(0, 1'b0);
        slave_err = 1'b0;

        // backpressure with a second command already offered
        slave_wait = 0; slave_dat = 32'hAAAA5555;
        drive_cmd(1'b0, 30'h010, 32'h0, 4'hF, 1'b1, 32'hAAAA5555, 1'b0, 1'b0, 1);
        accept_cmd();
        drive_cmd(1'b1, 30'h014, 32'h11223344, 4'h6, 1'b1, 32'h0, 1'b0, 1'b0, 1);
        wait_rsp(5, 1'b0);
        accept_cmd();
        wait_rsp(0, 1'b0);
        check("bp2_adr", cap_adr, 30'h014);
        check("bp2_datwr", cap_dat, 32'h11223344);
        check("bp2_sel", cap_sel, 4'h6);

        // reset during the bus cycle
        slave_silent = 1'b1;
        drive_cmd(1'b1, 30'h030, 32'h0BADF00D, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0, 0);
        accept_cmd();
        repeat (3) @(negedge clk48_host);
        #1;
        check("mid_cyc_before_rst", bus.wishbone_cyc, 1);
        reset = 1'b0;
        #1;
        check("arst_cyc", bus.wishbone_cyc, 0);
        check("arst_stb", bus.wishbone_stb, 0);
        check("arst_rsp_valid", bus.rsp_valid, 0);
        check("arst_cmd_ready", bus.cmd_ready, 0);
        repeat (2) @(negedge clk48_host);
        #1;
        check("arst_no_rsp", bus.rsp_valid, 0);
        slave_silent = 1'b0;
        reset = 1'b1;
        @(posedge clk48_host);
        #1;
        check("ready_after_arst", bus.cmd_ready, 1);
        slave_wait = 1;
        drive_cmd(1'b1, 30'h040, 32'hCAFEF00D, 4'h3, 1'b1, 32'h0, 1'b0, 1'b0, 2);
        accept_cmd();
        wait_rsp(0, 1'b0);
        check("post_rst_adr", cap_adr, 30'h040);
        check("post_rst_sel", cap_sel, 4'h3);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
